alm_div_top: RTL and testbench



---
 rtl/alm_div_pkg.sv | 21 ++
 rtl/alm_lod.sv | 39 +++
 rtl/alm_div_top.sv | 222 ++++++++++++++++++++++
 tb/tb_alm_div_top.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alm_div_pkg.sv
// alm_div_pkg: shared constants and types for the approximate log divider.
//   FRAC_W_DEF : default log-mantissa fraction width
//   Q_W_DEF    : default quotient width
//   LOG_CH_W   : characteristic width of a log word (covers 0..31)
//   SOA_M      : low fraction bits forced to one by the set-one subtractor
//   log_word_t : signed fixed-point log word {sign, characteristic, fraction}
package alm_div_pkg;

    localparam int unsigned FRAC_W_DEF = 11;
    localparam int unsigned Q_W_DEF    = 16;
    localparam int unsigned LOG_CH_W   = 5;
    localparam int unsigned SOA_M      = 4;

    // Log-domain word at default precision
    typedef struct packed {
        logic                  sign;
        logic [LOG_CH_W-1:0]   ch;
        logic [FRAC_W_DEF-1:0] frac;
    } log_word_t;

endpackage : alm_div_pkg

// File: rtl/alm_lod.sv
// alm_lod: leading-one detector plus mantissa aligner (purely combinational).
//   x_i         : unsigned operand
//   msb_idx_c_o : index of the leading one (0 when x_i is zero)
//   frac_c_o    : bits below the leading one, left-aligned to FRAC_W, truncated
//   zero_c_o    : x_i == 0
module alm_lod
    import alm_div_pkg::*;
#(
    parameter int unsigned W      = 32,
    parameter int unsigned FRAC_W = FRAC_W_DEF,
    parameter int unsigned IDX_W  = $clog2(W)
) (
    input  logic [W-1:0]      x_i,
    output logic [IDX_W-1:0]  msb_idx_c_o,
    output logic [FRAC_W-1:0] frac_c_o,
    output logic              zero_c_o
);

    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] sh;

    // Priority scan: the highest set bit wins
    always_comb begin : msb_scan
        idx = '0;
        for (int i = 0; i < W; i++) begin
            if (x_i[i]) begin
                idx = IDX_W'(i);
            end
        end
        sh = IDX_W'(W - 1) - idx;
    end

    // Normalise the leading one to the top of a W+FRAC_W field, then the next
    // FRAC_W bits down are the mantissa; zero padding covers narrow operands.
    assign frac_c_o    = FRAC_W'(({x_i, {FRAC_W{1'b0}}} << sh) >> (W - 1));
    assign msb_idx_c_o = idx;
    assign zero_c_o    = (x_i == '0);

endmodule : alm_lod

// File: rtl/alm_div_top.sv
// alm_div_top: 3-stage valid/ready Mitchell-style approximate divider.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready is combinational)
//   p, y                : 32-bit dividend, 16-bit divisor (unsigned)
//   out_valid/out_ready : result handshake
//   q, dz, ovf          : quotient, divide-by-zero flag, saturation flag
// Stages: 1 leading-one detect, 2 log subtract, 3 antilog + special cases.
// Build option: define ALM_DIV_SOA_EN for the set-one subtractor in stage 2.
module alm_div_top
    import alm_div_pkg::*;
#(
    parameter int unsigned FRAC_W = FRAC_W_DEF,
    parameter int unsigned Q_W    = Q_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [31:0]    p,
    input  logic [15:0]    y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [Q_W-1:0] q,
    output logic           dz,
    output logic           ovf
);

    localparam int unsigned P_W  = 32;
    localparam int unsigned Y_W  = 16;
    localparam int unsigned KP_W = $clog2(P_W);
    localparam int unsigned KY_W = $clog2(Y_W);
    localparam int unsigned LG_W = LOG_CH_W + FRAC_W;   // unsigned log magnitude
    localparam int unsigned LW   = 1 + LG_W;            // signed difference
    localparam int unsigned SH_W = FRAC_W + Q_W;        // antilog shifter

    logic en;

    // Stage 1 combinational LOD results
    logic [KP_W-1:0]   kp_c;
    logic [KY_W-1:0]   ky_c;
    logic [FRAC_W-1:0] fp_c;
    logic [FRAC_W-1:0] fy_c;
    logic              zp_c;
    logic              zy_c;

    // Pipeline registers
    logic              s1_vld_q, s1_vld_d;
    logic [KP_W-1:0]   s1_kp_q,  s1_kp_d;
    logic [FRAC_W-1:0] s1_fp_q,  s1_fp_d;
    logic              s1_zp_q,  s1_zp_d;
    logic [KY_W-1:0]   s1_ky_q,  s1_ky_d;
    logic [FRAC_W-1:0] s1_fy_q,  s1_fy_d;
    logic              s1_zy_q,  s1_zy_d;

    logic              s2_vld_q, s2_vld_d;
    logic [LW-1:0]     s2_l_q,   s2_l_d;
    logic              s2_zp_q,  s2_zp_d;
    logic              s2_zy_q,  s2_zy_d;

    logic              out_vld_q, out_vld_d;
    logic [Q_W-1:0]    q_q,       q_d;
    logic              dz_q,      dz_d;
    logic              ovf_q,     ovf_d;

    // Stage 2 / stage 3 combinational datapath
    logic [LG_W-1:0]     lp_c;
    logic [LG_W-1:0]     ly_c;
    logic [LW-1:0]       l_c;
    logic                l_neg_c;
    logic [LOG_CH_W-1:0] ch_c;
    logic [FRAC_W-1:0]   m_c;
    logic [SH_W-1:0]     sh_c;
    logic [Q_W-1:0]      q_c;
    logic                dz_c;
    logic                ovf_c;

    // Whole pipeline advances together unless a held result is blocking
    assign en       = !out_vld_q || out_ready;
    assign in_ready = en;

    alm_lod #(
        .W      (P_W),
        .FRAC_W (FRAC_W)
    ) u_lod_p (
        .x_i         (p),
        .msb_idx_c_o (kp_c),
        .frac_c_o    (fp_c),
        .zero_c_o    (zp_c)
    );

    alm_lod #(
        .W      (Y_W),
        .FRAC_W (FRAC_W)
    ) u_lod_y (
        .x_i         (y),
        .msb_idx_c_o (ky_c),
        .frac_c_o    (fy_c),
        .zero_c_o    (zy_c)
    );

    // Log words: characteristic concatenated with the aligned mantissa
    assign lp_c = {LOG_CH_W'(s1_kp_q), s1_fp_q};
    assign ly_c = {LOG_CH_W'(s1_ky_q), s1_fy_q};

`ifdef ALM_DIV_SOA_EN
    // Set-one subtractor: only the bits above SOA_M are subtracted exactly
    logic [LW-SOA_M-1:0] l_hi_c;
    assign l_hi_c = {1'b0, lp_c[LG_W-1:SOA_M]} - {1'b0, ly_c[LG_W-1:SOA_M]};
    assign l_c    = {l_hi_c, {SOA_M{1'b1}}};
`else
    // Exact two's-complement difference; the extra MSB is the sign
    assign l_c = {1'b0, lp_c} - {1'b0, ly_c};
`endif

    assign l_neg_c = s2_l_q[LW-1];
    assign ch_c    = s2_l_q[LW-2:FRAC_W];
    assign m_c     = s2_l_q[FRAC_W-1:0];

    // Antilog with special-case priority: zy, zp, negative log, saturation
    always_comb begin : antilog
        sh_c  = SH_W'({1'b1, m_c}) << ch_c;
        q_c   = '0;
        dz_c  = 1'b0;
        ovf_c = 1'b0;
        if (s2_zy_q) begin
            q_c  = '1;
            dz_c = 1'b1;
        end else if (s2_zp_q || l_neg_c) begin
            q_c = '0;
        end else if (32'(ch_c) >= Q_W) begin
            q_c   = '1;
            ovf_c = 1'b1;
        end else begin
            q_c = Q_W'(sh_c >> FRAC_W);
        end
    end

    // Next-state: hold everything on stall, load payloads only under valid
    always_comb begin : next_state
        s1_vld_d  = s1_vld_q;
        s1_kp_d   = s1_kp_q;
        s1_fp_d   = s1_fp_q;
        s1_zp_d   = s1_zp_q;
        s1_ky_d   = s1_ky_q;
        s1_fy_d   = s1_fy_q;
        s1_zy_d   = s1_zy_q;
        s2_vld_d  = s2_vld_q;
        s2_l_d    = s2_l_q;
        s2_zp_d   = s2_zp_q;
        s2_zy_d   = s2_zy_q;
        out_vld_d = out_vld_q;
        q_d       = q_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;
        if (en) begin
            s1_vld_d = in_valid;
            if (in_valid) begin
                s1_kp_d = kp_c;
                s1_fp_d = fp_c;
                s1_zp_d = zp_c;
                s1_ky_d = ky_c;
                s1_fy_d = fy_c;
                s1_zy_d = zy_c;
            end
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_l_d  = l_c;
                s2_zp_d = s1_zp_q;
                s2_zy_d = s1_zy_q;
            end
            out_vld_d = s2_vld_q;
            if (s2_vld_q) begin
                q_d   = q_c;
                dz_d  = dz_c;
                ovf_d = ovf_c;
            end
        end
    end

    // Pipeline state registers
    always_ff @(posedge clk or negedge rst_n) begin : pipe_regs
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_kp_q   <= '0;
            s1_fp_q   <= '0;
            s1_zp_q   <= 1'b0;
            s1_ky_q   <= '0;
            s1_fy_q   <= '0;
            s1_zy_q   <= 1'b0;
            s2_vld_q  <= 1'b0;
            s2_l_q    <= '0;
            s2_zp_q   <= 1'b0;
            s2_zy_q   <= 1'b0;
            out_vld_q <= 1'b0;
            q_q       <= '0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_kp_q   <= s1_kp_d;
            s1_fp_q   <= s1_fp_d;
            s1_zp_q   <= s1_zp_d;
            s1_ky_q   <= s1_ky_d;
            s1_fy_q   <= s1_fy_d;
            s1_zy_q   <= s1_zy_d;
            s2_vld_q  <= s2_vld_d;
            s2_l_q    <= s2_l_d;
            s2_zp_q   <= s2_zp_d;
            s2_zy_q   <= s2_zy_d;
            out_vld_q <= out_vld_d;
            q_q       <= q_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
        end
    end

    assign out_valid = out_vld_q;
    assign q         = q_q;
    assign dz        = dz_q;
    assign ovf       = ovf_q;

endmodule : alm_div_top

// File: tb/tb_alm_div_top.sv
// tb_alm_div_top: scoreboard bench for alm_div_top.
// Expected results are pushed when an operand pair is accepted and popped
// when a result transfers. Honours ALM_DIV_SOA_EN in its reference model.
module tb_alm_div_top;

    typedef struct packed {
        logic [15:0] q;
        logic        dz;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] p;
    logic [15:0] y;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] q;
    logic        dz;
    logic        ovf;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   rand_done;

    alm_div_top dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .p         (p),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .dz        (dz),
        .ovf       (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    endtask

    // Reference: logs as integers scaled by 2^11, then exponentiate
    function automatic exp_t model(input logic [31:0] pv, input logic [15:0] yv);
        exp_t   e;
        longint lp, ly, l, m;
        int     kp, ky, c;
        e = '0;
        if (yv == 16'd0) begin
            e.q  = 16'hFFFF;
            e.dz = 1'b1;
            return e;
        end
        if (pv == 32'd0) return e;
        kp = 0;
        for (int i = 0; i < 32; i++) if (pv[i]) kp = i;
        ky = 0;
        for (int i = 0; i < 16; i++) if (yv[i]) ky = i;
        lp = longint'(kp) * 2048 + (((longint'(pv) - (longint'(1) << kp)) * 2048) >>> kp);
        ly = longint'(ky) * 2048 + (((longint'(yv) - (longint'(1) << ky)) * 2048) >>> ky);
`ifdef ALM_DIV_SOA_EN
        l = ((lp >>> 4) - (ly >>> 4)) * 16 + 15;
`else
        l = lp - ly;
`endif
        if (l < 0) return e;
        c = int'(l / 2048);
        m = l % 2048;
        if (c >= 16) begin
            e.q   = 16'hFFFF;
            e.ovf = 1'b1;
            return e;
        end
        e.q = 16'(((2048 + m) << c) >>> 11);
        return e;
    endfunction

    // Present an operand pair until accepted; returns at posedge+2 after acceptance
    task automatic send_exp(input logic [31:0] pv, input logic [15:0] yv, input exp_t e);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        p        = pv;
        y        = yv;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_timeout", 32'(in_ready), 32'd1);
        else sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [31:0] pv, input logic [15:0] yv);
        send_exp(pv, yv, model(pv, yv));
    endtask

    // Drop in_valid with garbage operands that must not be sampled
    task automatic idle(input int n);
        in_valid = 1'b0;
        p        = $urandom;
        y        = 16'($urandom);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
        idle(2);
    endtask

    // Scoreboard consumer
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("stray_out", 32'(out_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("q",   32'(q),   32'(mon_e.q));
                check("dz",  32'(dz),  32'(mon_e.dz));
                check("ovf", 32'(ovf), 32'(mon_e.ovf));
            end
        end
    end

    initial begin : main
        logic [31:0] bp_p [5];
        logic [15:0] bp_y [5];
        int          lat;
        exp_t        e16k;

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        p         = '0;
        y         = '0;
        rand_done = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_q",         32'(q),         32'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("post_rst_in_ready",  32'(in_ready),  32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_dz",        32'(dz),        32'd0);
        check("post_rst_ovf",       32'(ovf),       32'd0);
        #1;

        // 100 / 10 with latency measurement
        send_exp(32'd100, 16'd10, '{16'd10, 1'b0, 1'b0});
        idle(0);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        check("latency", 32'(lat), 32'd3);
        drain();

        // Directed vectors and saturation boundaries, back to back
`ifdef ALM_DIV_SOA_EN
        e16k = model(32'd16384, 16'd4);
`else
        e16k = '{16'd4096, 1'b0, 1'b0};
`endif
        send_exp(32'd16384, 16'd4, e16k);
        send_exp(32'd1, 16'd2, '{16'd0, 1'b0, 1'b0});
        send_exp(32'd1234, 16'd0, '{16'hFFFF, 1'b1, 1'b0});
        send_exp(32'd0, 16'd7, '{16'd0, 1'b0, 1'b0});
        send_exp(32'hFFFF_FFFF, 16'd1, '{16'hFFFF, 1'b0, 1'b1});
        send_exp(32'd0, 16'd0, '{16'hFFFF, 1'b1, 1'b0});
        send(32'd32768, 16'd1);
        send(32'd65536, 16'd1);
        send(32'd65535, 16'd65535);
        idle(0);
        drain();

        // Back-pressure: 5 back-to-back, hold out_ready low 4 cycles at first result
        for (int i = 0; i < 5; i++) begin
            bp_p[i] = 32'd1000 * 32'(i + 1) + 32'd37;
            bp_y[i] = 16'(i + 3);
        end
        fork
            begin
                for (int i = 0; i < 5; i++) send(bp_p[i], bp_y[i]);
                idle(0);
            end
            begin : hold
                bit seen;
                seen = 1'b0;
                for (int i = 0; i < 30; i++) begin
                    @(posedge clk);
                    #2;
                    if (out_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                if (!seen) begin
                    check("bp_first_out", 32'(out_valid), 32'd1);
                end else begin
                    out_ready = 1'b0;
                    for (int c = 0; c < 4; c++) begin
                        @(negedge clk);
                        check("bp_in_ready",  32'(in_ready),  32'd0);
                        check("bp_out_valid", 32'(out_valid), 32'd1);
                        if (sb.size() > 0) check("bp_q_hold", 32'(q), 32'(sb[0].q));
                    end
                    @(posedge clk);
                    #2;
                    out_ready = 1'b1;
                end
            end
        join
        drain();

        // Reset with two operands in flight
        send(32'd5000, 16'd9);
        send(32'd777, 16'd3);
        idle(0);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_q",         32'(q),         32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        sb.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        idle(6);
        send(32'd77777, 16'd33);
        idle(0);
        drain();

        // Random operands with random gaps and random back-pressure
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    logic [31:0] pv;
                    logic [15:0] yv;
                    pv = $urandom >> $urandom_range(0, 31);
                    yv = 16'($urandom >> $urandom_range(16, 31));
                    if ($urandom_range(0, 15) == 0) pv = '0;
                    if ($urandom_range(0, 15) == 0) yv = '0;
                    send(pv, yv);
                    if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
                end
                idle(0);
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #2;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_alm_div_top
